uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Parametrised UART transmitter with an integrated TX FIFO and an internal baud divider.
//  Serialises DATA_BITS-wide words as start / data (LSB first) / optional parity / stop frames.
//  Frames queued in the FIFO go out back-to-back, with no idle gap between them.
//  Drops into the same slot as transmitter; its tx output feeds receiver.rx.
// PARAMETERS
//  DATA_BITS     8   data bits per frame; legal range 5..9
//  PARITY_MODE   0   0 = none, 1 = even, 2 = odd
//  STOP_BITS     1   number of stop bits; 1 or 2
//  CLKS_PER_BIT  16  clk cycles per bit period; >= 2
//  FIFO_DEPTH    4   FIFO entries; power of 2, >= 2
// PORTS
//  clk         in   1                         system clock, rising edge
//  rst_n       in   1                         asynchronous reset, active-low
//  din         in   DATA_BITS                 word to queue
//  wr_en       in   1                         push din into the FIFO this cycle
//  full        out  1                         FIFO holds FIFO_DEPTH entries
//  overflow    out  1                         1-cycle pulse: wr_en seen while full, word dropped
//  fifo_count  out  $clog2(FIFO_DEPTH)+1      number of queued words
//  tx          out  1                         serial line, idle high, registered output
//  tx_busy     out  1                         high when FSM != IDLE or FIFO not empty
// BEHAVIOUR
//  Reset (async, while rst_n = 0):
//   - tx = 1; tx_busy = 0; full = 0; overflow = 0; fifo_count = 0.
//   - FSM = IDLE; baud counter, bit counter and shift register cleared.
//  Reset mid-frame: tx returns high at once, the FIFO is flushed, the aborted frame is never resumed.
//  FIFO:
//   - A push is accepted when wr_en = 1 and full = 0, judged at the start of the cycle.
//   - Push and pop in the same cycle when not full: count is unchanged.
//   - wr_en while full: word dropped, even if a pop happens in the same cycle; overflow pulses.
//   - Pointers wrap modulo FIFO_DEPTH.
//  FSM states: IDLE, START, DATA, PARITY, STOP.
//   - Every bit lasts exactly CLKS_PER_BIT cycles, timed by a baud counter that reloads on each state entry.
//   - IDLE: tx = 1. When fifo_count != 0: pop into the shift register and enter START on the next edge.
//   - Latency: tx falls on the 2nd rising edge after the edge that sampled wr_en.
//   - START: tx = 0 -> DATA.
//   - DATA: tx = shift_reg[0]; shift right at the end of each bit; after DATA_BITS bits go to PARITY
//     (PARITY_MODE != 0) or to STOP.
//   - PARITY: tx = ^data when even, ~^data when odd; the value is captured at pop time.
//   - STOP: tx = 1 for STOP_BITS*CLKS_PER_BIT cycles.
//   - End of STOP: if the FIFO is not empty, pop and enter START on that same edge (zero gap);
//     otherwise go to IDLE.
//  Frame length = (1 + DATA_BITS + (PARITY_MODE != 0) + STOP_BITS) * CLKS_PER_BIT cycles.
//  tx_busy is combinational from the FSM state and fifo_count; it drops in the first IDLE cycle
//  that has an empty FIFO.
//  din is sampled only on accepted pushes; it may change freely at other times.
// STRUCTURE
//  - uart_pkg: tx_state_e enum; PARITY_NONE / PARITY_EVEN / PARITY_ODD localparams.
//  - Sub-module uart_fifo (params WIDTH, DEPTH): push/pop, full, empty, count.
//  - This module: baud counter, bit counter, shift register, FSM, tx output register.
// TESTING
//  1. 8N1, CLKS_PER_BIT=4; write 8'b01100011 once -> tx low 4 clk, then bits 1,1,0,0,0,1,1,0
//     (4 clk each), then high 4 clk; 40-clk frame; tx_busy falls at the frame end.
//  2. PARITY_MODE=1: din=8'h03 -> parity bit 0; din=8'h07 -> parity bit 1.
//     PARITY_MODE=2 with 8'h03 -> parity bit 1.
//  3. FIFO_DEPTH=4; 6 consecutive writes 8'hA0..8'hA5 -> first 5 accepted, 6th dropped with a
//     1-clk overflow pulse; 5 contiguous frames with tx never idle between them.
//  4. STOP_BITS=2, CLKS_PER_BIT=4 -> stop phase high 8 clk; the next queued frame's start bit
//     follows immediately.
//  5. Assert rst_n=0 mid DATA bit 3 with 2 words queued -> tx=1 and fifo_count=0 with no clock
//     edge; after release, tx stays high.
//  6. DATA_BITS=7, PARITY_MODE=2, din=7'h55 -> 7 data bits LSB first, parity bit 1, frame length
//     10*CLKS_PER_BIT.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmitter
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_e;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - synchronous FIFO with occupancy count and overflow pulse
// A push is judged against the full flag at the start of the cycle, so a pop never makes room for it.
module uart_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic                     o_overflow,
   output logic [$clog2(DEPTH):0]   o_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             r_overflow;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full     = (r_count == CW'(DEPTH));
   assign o_empty    = (r_count == '0);
   assign w_do_push  = i_push && !o_full;
   assign w_do_pop   = i_pop && !o_empty;
   assign o_data     = r_mem[r_rd_ptr];
   assign o_count    = r_count;
   assign o_overflow = r_overflow;

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         r_overflow <= i_push && o_full;
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter with integrated TX FIFO and baud divider
// tx is registered from the current state, so it trails the FSM by one cycle.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DATA_BITS    = 8,
   parameter int PARITY_MODE  = 0,
   parameter int STOP_BITS    = 1,
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [DATA_BITS-1:0]          din,
   input  logic                          wr_en,
   output logic                          full,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          tx,
   output logic                          tx_busy
);
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);

   tx_state_e            r_state;
   tx_state_e            w_next_state;
   logic [BAUD_W-1:0]    r_baud;
   logic [3:0]           r_bit_cnt;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_parity;
   logic                 r_tx;
   logic                 w_bit_end;
   logic                 w_pop;
   logic                 w_tx_next;
   logic                 w_fifo_empty;
   logic [DATA_BITS-1:0] w_fifo_data;

   uart_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_push     (wr_en),
      .i_data     (din),
      .i_pop      (w_pop),
      .o_data     (w_fifo_data),
      .o_full     (full),
      .o_empty    (w_fifo_empty),
      .o_overflow (overflow),
      .o_count    (fifo_count)
   );

   assign w_bit_end = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
   assign tx        = r_tx;
   assign tx_busy   = (r_state != ST_IDLE) || !w_fifo_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_pop        = 1'b0;
      w_tx_next    = 1'b1;
      case (r_state)
         ST_IDLE: begin
            if (!w_fifo_empty) begin
               w_pop        = 1'b1;
               w_next_state = ST_START;
            end
         end
         ST_START: begin
            w_tx_next = 1'b0;
            if (w_bit_end) begin
               w_next_state = ST_DATA;
            end
         end
         ST_DATA: begin
            w_tx_next = r_shift[0];
            if (w_bit_end && (r_bit_cnt == 4'(DATA_BITS - 1))) begin
               w_next_state = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end
         end
         ST_PARITY: begin
            w_tx_next = r_parity;
            if (w_bit_end) begin
               w_next_state = ST_STOP;
            end
         end
         ST_STOP: begin
            // Popping here keeps queued frames contiguous on the line
            if (w_bit_end && (r_bit_cnt == 4'(STOP_BITS - 1))) begin
               if (!w_fifo_empty) begin
                  w_pop        = 1'b1;
                  w_next_state = ST_START;
               end else begin
                  w_next_state = ST_IDLE;
               end
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_baud    <= '0;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_parity  <= 1'b0;
         r_tx      <= 1'b1;
      end else begin
         if (w_next_state != r_state) begin
            r_baud    <= '0;
            r_bit_cnt <= '0;
         end else if (r_state != ST_IDLE) begin
            if (w_bit_end) begin
               r_baud    <= '0;
               r_bit_cnt <= r_bit_cnt + 4'd1;
            end else begin
               r_baud <= r_baud + BAUD_W'(1);
            end
         end
         if (w_pop) begin
            r_shift  <= w_fifo_data;
            r_parity <= (PARITY_MODE == PARITY_ODD) ? ~^w_fifo_data : ^w_fifo_data;
         end else if ((r_state == ST_DATA) && w_bit_end) begin
            r_shift <= r_shift >> 1;
         end
         r_tx <= w_tx_next;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo across three parameter sets
`timescale 1ns/1ps
module tb_uart_tx_fifo;

   localparam int DBv[3]  = '{8, 8, 7};
   localparam int PMv[3]  = '{0, 1, 2};
   localparam int SBv[3]  = '{1, 2, 1};
   localparam int CPBv[3] = '{4, 4, 5};
   localparam int DPv[3]  = '{4, 4, 2};

   logic clk;
   logic rst_n;
   logic wr0, wr1, wr2;
   logic [7:0] din0, din1;
   logic [6:0] din2;
   logic tx0, tx1, tx2;
   logic busy0, busy1, busy2;
   logic full0, full1, full2;
   logic ovf0, ovf1, ovf2;
   logic [2:0] cnt0, cnt1;
   logic [1:0] cnt2;

   int cyc = 0;
   int n_checks = 0;
   int n_err = 0;
   int expq[3][$];
   int starts[3][$];
   int ov_cnt[3] = '{0, 0, 0};
   bit done = 0;

   uart_tx_fifo #(.DATA_BITS(DBv[0]), .PARITY_MODE(PMv[0]), .STOP_BITS(SBv[0]),
                  .CLKS_PER_BIT(CPBv[0]), .FIFO_DEPTH(DPv[0])) u_dut0 (
      .clk(clk), .rst_n(rst_n), .din(din0), .wr_en(wr0), .full(full0),
      .overflow(ovf0), .fifo_count(cnt0), .tx(tx0), .tx_busy(busy0));

   uart_tx_fifo #(.DATA_BITS(DBv[1]), .PARITY_MODE(PMv[1]), .STOP_BITS(SBv[1]),
                  .CLKS_PER_BIT(CPBv[1]), .FIFO_DEPTH(DPv[1])) u_dut1 (
      .clk(clk), .rst_n(rst_n), .din(din1), .wr_en(wr1), .full(full1),
      .overflow(ovf1), .fifo_count(cnt1), .tx(tx1), .tx_busy(busy1));

   uart_tx_fifo #(.DATA_BITS(DBv[2]), .PARITY_MODE(PMv[2]), .STOP_BITS(SBv[2]),
                  .CLKS_PER_BIT(CPBv[2]), .FIFO_DEPTH(DPv[2])) u_dut2 (
      .clk(clk), .rst_n(rst_n), .din(din2), .wr_en(wr2), .full(full2),
      .overflow(ovf2), .fifo_count(cnt2), .tx(tx2), .tx_busy(busy2));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (ovf0) ov_cnt[0] <= ov_cnt[0] + 1;
      if (ovf1) ov_cnt[1] <= ov_cnt[1] + 1;
      if (ovf2) ov_cnt[2] <= ov_cnt[2] + 1;
   end

   function automatic logic tx_of(input int s);
      case (s)
         0:       return tx0;
         1:       return tx1;
         default: return tx2;
      endcase
   endfunction

   function automatic logic busy_of(input int s);
      case (s)
         0:       return busy0;
         1:       return busy1;
         default: return busy2;
      endcase
   endfunction

   function automatic int nbits(input int s);
      return 1 + DBv[s] + ((PMv[s] != 0) ? 1 : 0) + SBv[s];
   endfunction

   // Level of bit slot k of the frame carrying word w, from the framing rules
   function automatic logic exp_bit(input int s, input int w, input int k);
      int ones;
      ones = $countones(w);
      if (k == 0) return 1'b0;
      if (k <= DBv[s]) return ((w >> (k - 1)) & 1) != 0;
      if ((PMv[s] != 0) && (k == DBv[s] + 1)) return (PMv[s] == 1) ? ((ones % 2) == 1) : ((ones % 2) == 0);
      return 1'b1;
   endfunction

   task automatic chk(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic push(input int s, input int w, output int pc);
      case (s)
         0:       begin wr0 = 1'b1; din0 = w[7:0]; end
         1:       begin wr1 = 1'b1; din1 = w[7:0]; end
         default: begin wr2 = 1'b1; din2 = w[6:0]; end
      endcase
      @(negedge clk);
      wr0 = 1'b0; wr1 = 1'b0; wr2 = 1'b0;
      din0 = 8'($urandom); din1 = 8'($urandom); din2 = 7'($urandom);
      pc = cyc;
   endtask

   task automatic wait_idle(input int s, input int budget);
      int n;
      n = 0;
      while (busy_of(s) && (n < budget)) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) chk("idle_timeout", n, 0);
      repeat (3) @(negedge clk);
   endtask

   task automatic monitor(input int s);
      int w, nb;
      bit bad, aborted;
      logic got, want;
      while (!done) begin
         @(negedge clk);
         if (!rst_n || (tx_of(s) !== 1'b0)) continue;
         starts[s].push_back(cyc);
         if (expq[s].size() == 0) begin
            chk($sformatf("frame_expected_dut%0d", s), 0, 1);
            for (int t = 0; (t < 2000) && (tx_of(s) === 1'b0); t++) @(negedge clk);
            continue;
         end
         w = expq[s].pop_front();
         nb = nbits(s);
         aborted = 0;
         for (int k = 0; (k < nb) && !aborted; k++) begin
            bad = 0;
            want = exp_bit(s, w, k);
            got = want;
            for (int c = 0; c < CPBv[s]; c++) begin
               if ((k != 0) || (c != 0)) @(negedge clk);
               if (!rst_n) begin
                  aborted = 1;
                  break;
               end
               if (tx_of(s) !== want) begin
                  bad = 1;
                  got = tx_of(s);
               end
            end
            if (!aborted) begin
               n_checks++;
               if (bad) begin
                  n_err++;
                  $display("FAIL frame dut%0d word %0h bit %0d: tx=%b expected %b", s, w, k, got, want);
               end
            end
         end
      end
   endtask

   initial fork
      monitor(0);
      monitor(1);
      monitor(2);
   join_none

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int p0, pc, n, lows, ov_base, w, len, mask;
      rst_n = 1'b0;
      wr0 = 1'b0; wr1 = 1'b0; wr2 = 1'b0;
      din0 = '0; din1 = '0; din2 = '0;
      repeat (2) @(negedge clk);
      chk("rst_tx0", tx0, 1);       chk("rst_busy0", busy0, 0);
      chk("rst_full0", full0, 0);   chk("rst_ovf0", ovf0, 0);
      chk("rst_cnt0", cnt0, 0);     chk("rst_tx2", tx2, 1);
      chk("rst_busy2", busy2, 0);   chk("rst_cnt2", cnt2, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 8N1 single frame: latency, busy window
      starts[0].delete();
      expq[0].push_back(8'h63);
      push(0, 8'h63, p0);
      chk("t1_busy_after_write", busy0, 1);
      while (cyc < p0 + 40) @(negedge clk);
      chk("t1_busy_in_stop", busy0, 1);
      while (cyc < p0 + 42) @(negedge clk);
      chk("t1_busy_after_frame", busy0, 0);
      wait_idle(0, 200);
      chk("t1_frames", starts[0].size(), 1);
      if (starts[0].size() == 1) chk("t1_latency", starts[0][0] - p0, 2);

      // Even parity with 2 stop bits, back-to-back
      starts[1].delete();
      expq[1].push_back(8'h03);
      expq[1].push_back(8'h07);
      push(1, 8'h03, p0);
      push(1, 8'h07, pc);
      wait_idle(1, 400);
      chk("t4_frames", starts[1].size(), 2);
      if (starts[1].size() == 2) chk("t4_gap", starts[1][1] - starts[1][0], 48);

      // 7 data bits, odd parity
      starts[2].delete();
      expq[2].push_back(7'h55);
      expq[2].push_back(7'h03);
      push(2, 7'h55, p0);
      push(2, 7'h03, pc);
      wait_idle(2, 400);
      chk("t6_frames", starts[2].size(), 2);
      if (starts[2].size() == 2) chk("t6_frame_len", starts[2][1] - starts[2][0], 50);

      // Overflow: 6 consecutive writes into depth 4
      starts[0].delete();
      ov_base = ov_cnt[0];
      for (int i = 0; i < 6; i++) begin
         if (i < 5) expq[0].push_back(8'hA0 + i);
         push(0, 8'hA0 + i, pc);
         if (i == 4) begin
            chk("t3_count_full", cnt0, 4);
            chk("t3_full", full0, 1);
         end
      end
      repeat (2) @(negedge clk);
      chk("t3_overflow_pulses", ov_cnt[0] - ov_base, 1);
      wait_idle(0, 600);
      chk("t3_frames", starts[0].size(), 5);
      if (starts[0].size() == 5)
         for (int i = 1; i < 5; i++) chk($sformatf("t3_gap%0d", i), starts[0][i] - starts[0][i-1], 40);

      // Reset mid DATA bit 3 with two words queued
      expq[0].push_back(8'h5A);
      expq[0].push_back(8'hC3);
      expq[0].push_back(8'h3C);
      push(0, 8'h5A, pc);
      push(0, 8'hC3, pc);
      push(0, 8'h3C, pc);
      n = 0;
      while (tx0 && (n < 100)) begin
         @(negedge clk);
         n++;
      end
      chk("t5_frame_started", tx0, 0);
      repeat (18) @(negedge clk);
      chk("t5_count_before", cnt0, 2);
      #1 rst_n = 1'b0;
      expq[0].delete();
      #1;
      chk("t5_tx_in_reset", tx0, 1);
      chk("t5_count_in_reset", cnt0, 0);
      chk("t5_busy_in_reset", busy0, 0);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      lows = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (tx0 !== 1'b1) lows++;
      end
      chk("t5_tx_idle_after", lows, 0);
      chk("t5_busy_after", busy0, 0);

      // Randomized bursts no longer than the FIFO depth
      ov_base = ov_cnt[0] + ov_cnt[1] + ov_cnt[2];
      for (int s = 0; s < 3; s++) begin
         mask = (1 << DBv[s]) - 1;
         for (int b = 0; b < 6; b++) begin
            len = $urandom_range(1, DPv[s]);
            for (int j = 0; j < len; j++) begin
               repeat ($urandom_range(0, 2)) @(negedge clk);
               w = $urandom & mask;
               expq[s].push_back(w);
               push(s, w, pc);
            end
            wait_idle(s, 2000);
         end
      end
      chk("rand_no_overflow", ov_cnt[0] + ov_cnt[1] + ov_cnt[2] - ov_base, 0);

      done = 1;
      for (int s = 0; s < 3; s++) chk($sformatf("leftover_dut%0d", s), expq[s].size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
